// File: rtl/fakeram_64x20_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// fakeram_ctrl_pkg : shared constants and types for the 64x20 fake SRAM front-end
// Revision: 1.0
// ============================================================================
package fakeram_ctrl_pkg;

    localparam int FAKERAM_BITS  = 20;
    localparam int FAKERAM_DEPTH = 64;
    localparam int FAKERAM_AW    = 6;

    typedef logic [FAKERAM_BITS-1:0] fakeram_word_t;

    typedef struct packed {
        logic                  we;
        logic [FAKERAM_AW-1:0] addr;
        fakeram_word_t         wdata;
    } fakeram_req_t;

endpackage
`default_nettype wire

// File: rtl/fakeram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// fakeram_rsp_fifo : small circular-buffer FIFO, head presented from registers
// Revision: 1.0
// ============================================================================
module fakeram_rsp_fifo #(
    parameter  int WIDTH = 20,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage is reset too so the head reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fakeram_64x20_req_ctrl.sv
`default_nettype none
// ============================================================================
// fakeram_64x20_req_ctrl : request issue/credit front-end for the 64x20 fake SRAM
// Revision: 1.0
// ============================================================================
module fakeram_64x20_req_ctrl
    import fakeram_ctrl_pkg::*;
#(
    parameter int BITS       = FAKERAM_BITS,
    parameter int WORD_DEPTH = FAKERAM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(WORD_DEPTH),
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS-1:0]       rsp_data,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [BITS-1:0]       ram_wd,
    input  logic [BITS-1:0]       ram_rd
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          inflight;
    logic [CW-1:0] occ;
    logic          fifo_empty;
    logic          pop;
    logic [CW:0]   level;
    logic          rd_credit;
    logic          rd_issue;

    assign rsp_valid = ~fifo_empty;
    assign pop       = rsp_valid & rsp_ready;

    // Slots committed after this edge; pop implies occ >= 1, so no underflow.
    assign level     = {1'b0, occ} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign rd_credit = (level < (CW+1)'(RSP_DEPTH));

    assign req_ready = rst_n & (req_we | rd_credit);
    assign ram_ce    = req_valid & req_ready;
    assign ram_we    = ram_ce & req_we;
    assign ram_addr  = ram_ce ? req_addr : '0;
    assign ram_wd    = ram_we ? req_wdata : '0;
    assign rd_issue  = ram_ce & ~req_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_issue;
        end
    end

    fakeram_rsp_fifo #(
        .WIDTH (BITS),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (ram_rd),
        .pop       (pop),
        .pop_data  (rsp_data),
        .count     (occ),
        .empty     (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_fakeram_64x20_req_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fakeram_64x20_req_ctrl : self-checking bench with macro model and scoreboard
// Revision: 1.0
// ============================================================================
module tb_fakeram_64x20_req_ctrl;
    import fakeram_ctrl_pkg::*;

    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [5:0]    req_addr;
    fakeram_word_t req_wdata;
    logic          rsp_valid, rsp_ready;
    fakeram_word_t rsp_data;
    logic          ram_ce, ram_we;
    logic [5:0]    ram_addr;
    fakeram_word_t ram_wd, ram_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fakeram_64x20_req_ctrl #(
        .BITS (20), .WORD_DEPTH (64), .ADDR_WIDTH (6), .RSP_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
        .ram_ce (ram_ce), .ram_we (ram_we), .ram_addr (ram_addr),
        .ram_wd (ram_wd), .ram_rd (ram_rd)
    );

    // Behavioural macro: OR-merging writes, registered 1-cycle read data.
    fakeram_word_t macro_mem [64];
    fakeram_word_t macro_rd = '0;
    initial for (int i = 0; i < 64; i++) macro_mem[i] = '0;
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) macro_mem[ram_addr] <= macro_mem[ram_addr] | ram_wd;
            else        macro_rd <= macro_mem[ram_addr];
        end
    end
    assign ram_rd = macro_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: memory image plus queue of outstanding reads.
    typedef struct { fakeram_word_t data; int cyc; } exp_t;
    exp_t          exp_q[$];
    fakeram_word_t ref_mem [64];
    int            cyc = 0;
    initial for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    always @(negedge clk) begin
        logic pv, pop_e, er, hs;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            pv = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
            chk("mon_rsp_valid", 32'(rsp_valid), 32'(pv));
            if (pv) chk("mon_rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
            pop_e = pv & rsp_ready;
            er = req_we ? 1'b1 : ((exp_q.size() - int'(pop_e)) < DEPTH);
            chk("mon_req_ready", 32'(req_ready), 32'(er));
            hs = req_valid & er;
            chk("mon_ram_ce",   32'(ram_ce),   32'(hs));
            chk("mon_ram_we",   32'(ram_we),   32'(hs & req_we));
            chk("mon_ram_addr", 32'(ram_addr), 32'(hs ? req_addr : 6'd0));
            chk("mon_ram_wd",   32'(ram_wd),   32'((hs && req_we) ? req_wdata : 20'd0));
            if (pop_e) void'(exp_q.pop_front());
            if (hs && req_we)  ref_mem[req_addr] = ref_mem[req_addr] | req_wdata;
            else if (hs)       exp_q.push_back('{data: ref_mem[req_addr], cyc: cyc});
        end
        cyc++;
    end

    task automatic drive(input logic v, input logic we, input logic [5:0] a, input fakeram_word_t d);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic v, we; logic [5:0] a; fakeram_word_t d; logic rr;
        logic e_ready, e_ce, e_we; logic [5:0] e_addr; fakeram_word_t e_wd;
    } vec_t;
    vec_t tbl[5];

    fakeram_word_t got[$];
    int n_rsp, first_i, last_i;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 6'h3F, 20'hFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 6'h3F, 20'hFFFFF};
        tbl[1] = '{1'b1, 1'b0, 6'h2A, 20'hABCDE, 1'b1, 1'b1, 1'b1, 1'b0, 6'h2A, 20'h00000};
        tbl[2] = '{1'b0, 1'b1, 6'h15, 20'h12345, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 20'h00000};
        tbl[3] = '{1'b1, 1'b1, 6'h00, 20'h12345, 1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 20'h12345};
        tbl[4] = '{1'b0, 1'b0, 6'h01, 20'h55555, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 20'h00000};

        rst_n = 1'b0; rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 6'd3, 20'd0);
        tick(); tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data",  32'(rsp_data),  32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_ram_ce",    32'(ram_ce),    32'd0);
        drive(1'b0, 1'b0, 6'd0, 20'd0);
        rst_n = 1'b1;
        tick();

        // Pin hygiene with undriven request fields.
        req_valid = 1'b0; req_we = 1'bx; req_addr = 'x; req_wdata = 'x;
        #1;
        chk("hyg_ram_ce",   32'(ram_ce),   32'd0);
        chk("hyg_ram_we",   32'(ram_we),   32'd0);
        chk("hyg_ram_addr", 32'(ram_addr), 32'd0);
        chk("hyg_ram_wd",   32'(ram_wd),   32'd0);
        tick();

        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d);
            rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d_ram_ce", i),    32'(ram_ce),    32'(tbl[i].e_ce));
            chk($sformatf("vec%0d_ram_we", i),    32'(ram_we),    32'(tbl[i].e_we));
            chk($sformatf("vec%0d_ram_addr", i),  32'(ram_addr),  32'(tbl[i].e_addr));
            chk($sformatf("vec%0d_ram_wd", i),    32'(ram_wd),    32'(tbl[i].e_wd));
            tick();
            drive(1'b0, 1'b0, 6'd0, 20'd0); rsp_ready = 1'b1;
            repeat (3) tick();
        end

        // Basic write then read with 2-cycle latency.
        drive(1'b1, 1'b1, 6'd5, 20'h0000F); tick();
        drive(1'b1, 1'b1, 6'd7, 20'h00070); tick();
        drive(1'b1, 1'b0, 6'd5, 20'd0);     tick();
        drive(1'b0, 1'b0, 6'd0, 20'd0);
        chk("basic_not_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("basic_valid", 32'(rsp_valid), 32'd1);
        chk("basic_data",  32'(rsp_data),  32'h0000F);
        tick(); tick();

        // OR-merge with back-to-back write/read of the same word.
        drive(1'b1, 1'b1, 6'd9, 20'h00F00); tick();
        drive(1'b1, 1'b1, 6'd9, 20'h0000F); tick();
        drive(1'b1, 1'b0, 6'd9, 20'd0);     tick();
        drive(1'b0, 1'b0, 6'd0, 20'd0);     tick();
        chk("merge_valid", 32'(rsp_valid), 32'd1);
        chk("merge_data",  32'(rsp_data),  32'h00F0F);
        tick(); tick();

        // Backpressure: two reads fill the credit, third waits.
        drive(1'b1, 1'b1, 6'd1, 20'h11111); tick();
        drive(1'b1, 1'b1, 6'd2, 20'h22222); tick();
        drive(1'b1, 1'b1, 6'd3, 20'h33333); tick();
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 6'd1, 20'd0); chk("bp_rd1_ready", 32'(req_ready), 32'd1); tick();
        drive(1'b1, 1'b0, 6'd2, 20'd0); chk("bp_rd2_ready", 32'(req_ready), 32'd1); tick();
        drive(1'b1, 1'b0, 6'd3, 20'd0); chk("bp_rd3_blocked", 32'(req_ready), 32'd0); tick();
        chk("bp_rd3_still_blocked", 32'(req_ready), 32'd0);
        chk("bp_hold_data", 32'(rsp_data), 32'h11111);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        got.delete();
        for (int j = 0; j < 8; j++) begin
            logic hs;
            hs = req_valid & req_ready;
            if (rsp_valid && rsp_ready) got.push_back(rsp_data);
            tick();
            if (hs) drive(1'b0, 1'b0, 6'd0, 20'd0);
        end
        chk("bp_rsp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp_rsp0", 32'(got[0]), 32'h11111);
            chk("bp_rsp1", 32'(got[1]), 32'h22222);
            chk("bp_rsp2", 32'(got[2]), 32'h33333);
        end

        // Streaming 64 reads exercises pointer wrap.
        n_rsp = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < 68; i++) begin
            if (i < 64) drive(1'b1, 1'b0, 6'(i), 20'd0);
            else        drive(1'b0, 1'b0, 6'd0, 20'd0);
            #1;
            if (i < 64) chk("stream_ready", 32'(req_ready), 32'd1);
            if (rsp_valid) begin
                n_rsp++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
            tick();
        end
        chk("stream_count",  32'(n_rsp), 32'd64);
        chk("stream_first",  32'(first_i), 32'd2);
        chk("stream_contig", 32'(last_i - first_i + 1), 32'd64);

        // Reset with one read in flight and one buffered.
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 6'd5, 20'd0); tick();
        drive(1'b1, 1'b0, 6'd9, 20'd0); tick();
        drive(1'b1, 1'b0, 6'd1, 20'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_ram_ce",    32'(ram_ce),    32'd0);
        tick(); tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 6'd7, 20'd0); tick();
        drive(1'b0, 1'b0, 6'd0, 20'd0);
        got.delete();
        for (int j = 0; j < 6; j++) begin
            if (rsp_valid && rsp_ready) got.push_back(rsp_data);
            tick();
        end
        chk("rst_after_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("rst_after_data", 32'(got[0]), 32'h00070);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) == 0,
                  6'(40 + $urandom_range(0, 7)), 20'(1 << $urandom_range(0, 19)));
            rsp_ready = ($urandom % 3) != 0;
            tick();
        end
        drive(1'b0, 1'b0, 6'd0, 20'd0);
        rsp_ready = 1'b1;
        repeat (6) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fakeram_64x20_req_ctrl.md
# fakeram_64x20_req_ctrl

Request front-end for the 64x20 single-port fake SRAM macro. It accepts read/write requests on a valid/ready channel and drives the macro's `ce_in`, `we_in`, `addr_in` and `wd_in` pins. It captures the macro's 1-cycle read data into a small response FIFO, presented on a valid/ready channel. It sits between any requester (CPU-side test logic, DMA) and the macro, and guarantees that no read datum is lost under response backpressure.

## Interface

**Parameters**
- `BITS`, 20: data width; equals the macro's `BITS`.
- `WORD_DEPTH`, 64: words in the macro.
- `ADDR_WIDTH`, 6: address width; clog2(`WORD_DEPTH`).
- `RSP_DEPTH`, 2: response FIFO entries; minimum 2.

**Ports**
- `clk`, in, 1: single clock. The macro is clocked by the same net.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted this cycle when both are high.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, `ADDR_WIDTH`: word address.
- `req_wdata`, in, `BITS`: write data.
- `rsp_valid`, out, 1: read data available.
- `rsp_ready`, in, 1: consumer takes data.
- `rsp_data`, out, `BITS`: read data, FIFO head.
- `ram_ce`, out, 1: to macro `ce_in`.
- `ram_we`, out, 1: to macro `we_in`.
- `ram_addr`, out, `ADDR_WIDTH`: to macro `addr_in`.
- `ram_wd`, out, `BITS`: to macro `wd_in`.
- `ram_rd`, in, `BITS`: from macro `rd_out`.

## Operation

**Issue rule**
- Writes are always accepted: `req_ready` = 1 when `req_we` = 1.
- Reads are accepted when `occ + inflight - pop < RSP_DEPTH`, where:
  - `occ` is the FIFO count,
  - `inflight` is a 1-bit flag set on the cycle after a read issue,
  - `pop` = `rsp_valid & rsp_ready`.

**RAM pin drive (combinational from the request channel)**
- `ram_ce` = `req_valid & req_ready`.
- `ram_we` = `ram_ce & req_we`.
- `ram_addr` = `req_addr` when `ram_ce` = 1, else 0.
- `ram_wd` = `req_wdata` when `ram_we` = 1, else 0.
- No X is ever driven on `ram_we` or `ram_addr` while `ram_ce` = 1.

**Write semantics**
- The macro OR-merges write data into the stored word.
- This block does not compensate. Writes produce no response.

**Capture**
- `inflight` is set at edge N when a read issues.
- At edge N+1, `ram_rd` is pushed into the FIFO and `inflight` clears, unless another read issued at N+1.
- The push never overflows; the issue rule guarantees space.

**FIFO**
- Circular buffer with wrapping read/write pointers.
- A simultaneous push and pop leaves `occ` unchanged.
- Push into an empty FIFO becomes visible on `rsp_valid` the following cycle; there is no bypass.

**Ordering**
- Responses return in read-issue order.
- A read issued the cycle after a write to the same address returns the merged value.

**Reset**
- `rst_n` low asynchronously clears `occ`, the pointers and `inflight`.
- `rsp_valid` = 0; `ram_ce` = 0, since `req_ready` is forced 0 during reset.
- `rsp_data` resets to 0.
- An in-flight read is discarded.

## Timing

- **Read latency:** accepted at edge N → `rsp_valid` high after edge N+1, i.e. 2 cycles after `req_valid` was presented.
- **Throughput:** one read per cycle sustained while `rsp_ready` = 1. With `RSP_DEPTH` = 2 and `rsp_ready` = 0, at most 2 reads are outstanding, then `req_ready` = 0 for reads.
- **Write-to-read:** write at edge N, read of the same address at edge N+1 is legal with no bubble.
- **Combinational paths:** `req_ready` depends combinationally on `req_we` and `rsp_ready`. All `ram_*` outputs are combinational from the request channel. There is no path from `ram_rd` to any output except through the FIFO register.
- **Response hold:** `rsp_data` is stable while `rsp_valid & !rsp_ready`.

## Structure

- **Package `fakeram_ctrl_pkg`**
  - constants `FAKERAM_BITS` = 20, `FAKERAM_DEPTH` = 64, `FAKERAM_AW` = 6;
  - typedef `fakeram_req_t` {we, addr, wdata};
  - typedef `fakeram_word_t`.
- **Sub-module `fakeram_rsp_fifo`**
  - parameterised on width and depth;
  - push/pop, count, async active-low reset.
  - Reusable for other macro wrappers.
- **Top level:** issue/credit logic and the `inflight` flag only.

## Test plan

- **Basic read/write:** write addr 5 = 0x0000F, then read addr 5 → `rsp_data` = 0x0000F exactly 2 cycles after the read handshake.
- **OR-merge:** write addr 9 = 0x00F00, write addr 9 = 0x0000F, read addr 9 → 0x00F0F.
- **Backpressure:** `rsp_ready` = 0, issue reads to addrs 1, 2, 3 → `req_ready` drops after the 2nd read. Release `rsp_ready` → responses for addrs 1, 2, 3 arrive in order and none are lost.
- **Streaming:** 64 back-to-back reads with `rsp_ready` = 1 → `req_ready` stays 1 throughout and 64 responses arrive on consecutive cycles, exercising FIFO pointer wrap.
- **Reset mid-operation:** assert `rst_n` low with 1 read in flight and 1 buffered → `rsp_valid` = 0 immediately. After release, the first new read returns only its own data.
- **Pin hygiene:** idle cycles with X on `req_addr` and `req_valid` = 0 → `ram_ce` = 0, `ram_addr` = 0, and the macro never reports an X warning.
